// File: rtl/dmem_responder_pkg.sv
// Shared types and address constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int LANES = WORD_SIZE / 8;

  typedef logic [WORD_SIZE-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0] data_t;
  typedef logic [LANES-1:0]     wen_t;

  localparam addr_t MMIO_BASE    = 32'h8000_0000;
  localparam addr_t CON_DATA_OFF = 32'h0000_0000;
  localparam addr_t CON_STAT_OFF = 32'h0000_0004;
  localparam addr_t MTIME_OFF    = 32'h0000_0008;
  localparam addr_t MTIMECMP_OFF = 32'h0000_000C;

  localparam int unsigned STAT_EMPTY      = 0;
  localparam int unsigned STAT_FULL       = 1;
  localparam int unsigned STAT_OVERFLOW   = 2;
  localparam int unsigned STAT_BAD_ACCESS = 3;

  typedef enum logic [2:0] {
    RegNone,
    RegRam,
    RegConData,
    RegConStat,
    RegMtime,
    RegMtimecmp
  } region_e;

  function automatic data_t lane_merge(data_t old, data_t wd, wen_t wen);
    data_t res;
    res = old;
    for (int n = 0; n < LANES; n++) begin
      if (wen[n]) res[8*n +: 8] = wd[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory port plus console TX stream and timer interrupt.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  addr_t      addr;
  data_t      wd;
  wen_t       wen;
  logic       ren;
  data_t      rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       timer_irq;

  modport master (
    output addr, wd, wen, ren, tx_ready,
    input  rd, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  addr, wd, wen, ren, tx_ready,
    output rd, tx_data, tx_valid, timer_irq
  );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Synchronous FIFO for console TX; a push while full is taken only alongside a pop.
module dmem_responder_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero when empty so the output has a defined reset value.
  assign rdata   = empty ? '0 : mem[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: local RAM plus MMIO console FIFO and machine timer.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_DIV   = 1
) (
  input logic              clk,
  input logic              rstn,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam addr_t CON_DATA_ADDR = MMIO_BASE + CON_DATA_OFF;
  localparam addr_t CON_STAT_ADDR = MMIO_BASE + CON_STAT_OFF;
  localparam addr_t MTIME_ADDR    = MMIO_BASE + MTIME_OFF;
  localparam addr_t MTIMECMP_ADDR = MMIO_BASE + MTIMECMP_OFF;

  region_e         region;
  logic [AW-1:0]   ram_idx;
  data_t           mem [DEPTH];
  logic            wr_any, access;

  logic            push, pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            stat_wr;
  logic            overflow_q, overflow_d, bad_q, bad_d;

  logic [PW-1:0]   presc_q, presc_d;
  data_t           mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic            irq_q, tick, mtime_wr;
  data_t           stat, rd_d;

  always_comb begin
    region = RegNone;
    if ((bus.addr >> (AW + 2)) == '0)                                 region = RegRam;
    else if (bus.addr[WORD_SIZE-1:2] == CON_DATA_ADDR[WORD_SIZE-1:2]) region = RegConData;
    else if (bus.addr[WORD_SIZE-1:2] == CON_STAT_ADDR[WORD_SIZE-1:2]) region = RegConStat;
    else if (bus.addr[WORD_SIZE-1:2] == MTIME_ADDR[WORD_SIZE-1:2])    region = RegMtime;
    else if (bus.addr[WORD_SIZE-1:2] == MTIMECMP_ADDR[WORD_SIZE-1:2]) region = RegMtimecmp;
  end

  assign ram_idx = bus.addr[AW+1:2];
  assign wr_any  = |bus.wen;
  assign access  = bus.ren | wr_any;

  // RAM is deliberately left unreset; writes are still blocked during reset.
  always_ff @(posedge clk) begin
    if (rstn && region == RegRam) begin
      for (int n = 0; n < LANES; n++) begin
        if (bus.wen[n]) mem[ram_idx][8*n +: 8] <= bus.wd[8*n +: 8];
      end
    end
  end

  assign push = (region == RegConData) & bus.wen[0];
  assign pop  = ~fifo_empty & bus.tx_ready;

  dmem_responder_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (bus.wd[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = ~fifo_empty;
  assign stat_wr      = (region == RegConStat) & bus.wen[0];

  always_comb begin
    overflow_d = overflow_q;
    bad_d      = bad_q;
    if (push && fifo_count == CW'(FIFO_DEPTH) && !pop) overflow_d = 1'b1;
    if (stat_wr && bus.wd[STAT_OVERFLOW])              overflow_d = 1'b0;
    if (region == RegNone && access)                   bad_d      = 1'b1;
    if (stat_wr && bus.wd[STAT_BAD_ACCESS])            bad_d      = 1'b0;
  end

  assign mtime_wr = (region == RegMtime) & wr_any;
  assign tick     = (presc_q == PW'(TICK_DIV - 1));

  // A CPU write to MTIME suppresses that cycle's increment and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (mtime_wr) begin
      mtime_d = lane_merge(mtime_q, bus.wd, bus.wen);
      presc_d = '0;
    end else if (tick) begin
      mtime_d = mtime_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    mtimecmp_d = (region == RegMtimecmp) ? lane_merge(mtimecmp_q, bus.wd, bus.wen) : mtimecmp_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.timer_irq = irq_q;

  always_comb begin
    stat                  = '0;
    stat[STAT_EMPTY]      = fifo_empty;
    stat[STAT_FULL]       = fifo_full;
    stat[STAT_OVERFLOW]   = overflow_q;
    stat[STAT_BAD_ACCESS] = bad_q;
  end

  always_comb begin
    rd_d = '0;
    if (bus.ren) begin
      case (region)
        RegRam:      rd_d = mem[ram_idx];
        RegConStat:  rd_d = stat;
        RegMtime:    rd_d = mtime_q;
        RegMtimecmp: rd_d = mtimecmp_q;
        default:     rd_d = '0;
      endcase
    end
  end

  assign bus.rd = rd_d;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory port. Serves word reads and byte-lane writes issued by the single-cycle core to a local RAM, and decodes a small MMIO window holding a console TX FIFO and a machine timer. Sits beside the core at top level, attached directly to the core's DM address, write-data, write-enable, read-enable and read-data signals.

## Interface
- DEPTH, 1024: RAM size in 32-bit words, power of 2.
- FIFO_DEPTH, 8: console TX FIFO entries, power of 2, ≥2.
- TICK_DIV, 1: core clocks per mtime increment, ≥1.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_DM_addr  in  32  byte address (addr_t).
- i_DM_wd  in  32  write data (data_t).
- i_DM_wen  in  4  byte-lane write enables; lane n is wd[8n+7:8n].
- i_DM_ren  in  1  read enable.
- o_DM_rd  out  32  read data, combinational, same cycle.
- o_tx_data  out  8  FIFO head byte.
- o_tx_valid  out  1  FIFO not empty.
- i_tx_ready  in  1  consumer accepts head when valid.
- o_timer_irq  out  1  registered mtime ≥ mtimecmp (unsigned).

## Operation
- Address map, decoded on full 32-bit address; addr[1:0] are ignored, so lane alignment is the core's job:
  - 0x0000_0000 up to DEPTH*4-1: RAM at word index addr[log2(DEPTH)+1:2].
  - 0x8000_0000 CON_DATA: a write with wen[0] pushes wd[7:0]. Reads return 0.
  - 0x8000_0004 CON_STAT: read {28'b0, bad_access, overflow, full, empty}. A write with wen[0] clears overflow if wd[2]=1 and clears bad_access if wd[3]=1.
  - 0x8000_0008 MTIME and 0x8000_000C MTIMECMP: read/write with per-lane enables.
  - Any other address: reads 0 and writes are ignored. If ren or any wen is set, bad_access is set (sticky).
- o_DM_rd is 0 whenever i_DM_ren=0. Reads have no side effects.
- RAM: per-lane write at the clock edge. A read in the same cycle as a write returns the old word.
- FIFO:
  - push = CON_DATA write with wen[0]; pop = o_tx_valid & i_tx_ready.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
  - Push and pop together when not full leaves the count unchanged.
  - o_tx_data is stable while valid and not popped.
- Timer:
  - A prescaler counts 0..TICK_DIV-1; mtime increments (wrapping at 2^32) when the prescaler equals TICK_DIV-1.
  - A CPU write to MTIME in the same cycle wins over the increment: written lanes take wd, unwritten lanes keep the old value (not incremented), and the prescaler is reset to 0.
- RAM contents are not reset. All writes are ignored while i_rstn=0.

## Timing
- Reset values: FIFO empty (o_tx_valid=0, o_tx_data=0), overflow=0, bad_access=0, mtime=0, mtimecmp=0xFFFF_FFFF, prescaler=0, o_timer_irq=0.
- Read latency is 0 cycles (combinational, same cycle as the address).
- Write takes effect at the next rising edge; a read one cycle later sees the new value.
- Pushed byte appears on o_tx_data/o_tx_valid the cycle after the push edge.
- o_timer_irq has 1-cycle latency from register values. Compare uses the post-edge mtime/mtimecmp, so irq rises one cycle after equality is reached.
- Reset asserted mid-operation flushes the FIFO and timer on that edge and discards any in-flight push or write.

## Structure
- Shared package holds addr_t/data_t (WORD_SIZE), the MMIO base and offset constants, and the CON_STAT bit positions.
- One sub-module: tx_fifo (parameterized sync FIFO with push, pop, full, empty, count). RAM, decode and timer live in dmem_responder.

## Test plan
- RAM byte lanes: write 0xAABBCCDD wen=1111 to 0x10, then 0x11223344 wen=0101 -> read of 0x10 returns 0xAA22CC44; a read with ren=0 returns 0.
- FIFO fill/overflow, FIFO_DEPTH=8, i_tx_ready=0: push 0x01..0x09 -> CON_STAT=0x6 (full+overflow). Raise ready -> bytes 0x01..0x08 drain in order, then CON_STAT=0x5. Write 0x4 -> CON_STAT=0x1.
- Push while full with simultaneous pop -> accepted, count stays 8, overflow stays 0.
- Timer, TICK_DIV=2: after reset, MTIME reads 5 after 10 cycles. Write MTIMECMP=8 -> irq rises one cycle after mtime becomes 8. Write MTIME=0 with wen=1111 -> irq falls next cycle.
- Unmapped read at 0x4000_0000 with ren=1 -> returns 0 and CON_STAT bit3=1. Unmapped write -> RAM unchanged.
- Reset mid-stream with 3 bytes queued and mtime=100 -> next cycle o_tx_valid=0, mtime=0, RAM word written before reset is still readable.
